decode_uop_queue: RTL and testbench

- Parametrised decode-front buffer between fetch and the per-lane decoded-instruction generator.
- Accepts up to FETCH_W pre-classified instructions per cycle and cracks HI/LO-writing multiply/divide ops into two ordered micro-ops (is_inst2 = 0, then 1).
- Holds the micro-ops in a circular queue and presents up to OUT_W micro-ops per cycle, in order, to the decode lanes.
- Replaces the fixed two-slot, always-split-in-place scheme with depth, width and back-pressure handling.

---
 rtl/decode_uop_queue_pkg.sv | 51 +++++
 rtl/decode_uop_queue_uop_expander.sv | 53 +++++
 rtl/decode_uop_queue.sv | 131 +++++++++++++
 tb/tb_decode_uop_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_uop_queue_pkg.sv
`default_nettype none
//============================================================================
// Module   : decode_uop_queue_pkg
// Brief    : Shared types and crack-set helper for the decode micro-op queue.
// Revision : 1.0 - initial release
//============================================================================
package decode_uop_queue_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADDU, OP_OR, OP_AND, OP_LW, OP_SW, OP_BEQ, OP_MFHI,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
    OP_MUL
  } operation_t;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef struct packed {
    logic       ex;
    logic [4:0] exccode;
  } exception_t;

  typedef struct packed {
    virt_t      pc;
    uint32_t    inst;
    operation_t operation;
    exception_t exception;
    logic       is_inst2;
  } uop_t;

  // Queue must hold at least one worst-case group of DEPTH_MIN uops per lane.
  localparam int DEPTH_MIN = 2;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic is_cracked_op(input operation_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU, OP_MUL: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_uop_queue_uop_expander.sv
`default_nettype none
//============================================================================
// Module   : uop_expander
// Brief    : Cracks a fetch group into a packed, ordered list of micro-ops.
// Revision : 1.0 - initial release
//============================================================================
module uop_expander
  import decode_uop_queue_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int CNT_W   = 5
) (
  input  logic       [FETCH_W-1:0]   valid_i,
  input  virt_t      [FETCH_W-1:0]   pc_i,
  input  uint32_t    [FETCH_W-1:0]   inst_i,
  input  operation_t [FETCH_W-1:0]   operation_i,
  input  exception_t [FETCH_W-1:0]   exception_i,
  output uop_t       [2*FETCH_W-1:0] uops_o,
  output logic       [CNT_W-1:0]     count_o
);

  localparam int IW = $clog2(2 * FETCH_W);

  logic [CNT_W-1:0] wr_off;

  // wr_off is the running prefix sum, so slot order matches lane order.
  always_comb begin
    uops_o = '0;
    wr_off = '0;
    for (int l = 0; l < FETCH_W; l++) begin
      uop_t u;
      u           = '0;
      u.pc        = pc_i[l];
      u.inst      = inst_i[l];
      u.operation = operation_i[l];
      u.exception = exception_i[l];
      u.is_inst2  = 1'b0;
      if (valid_i[l]) begin
        uops_o[IW'(wr_off)] = u;
        if (is_cracked_op(operation_i[l]) && !exception_i[l].ex) begin
          u.is_inst2 = 1'b1;
          uops_o[IW'(wr_off + CNT_W'(1))] = u;
          wr_off = wr_off + CNT_W'(2);
        end else begin
          wr_off = wr_off + CNT_W'(1);
        end
      end
    end
    count_o = wr_off;
  end

endmodule
`default_nettype wire

// File: rtl/decode_uop_queue.sv
`default_nettype none
//============================================================================
// Module   : decode_uop_queue
// Brief    : Circular micro-op queue between fetch and the decode lanes.
//            DECODE_ATOMIC_PAIR_EN keeps cracked halves in one output beat.
// Revision : 1.0 - initial release
//============================================================================
module decode_uop_queue
  import decode_uop_queue_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int OUT_W   = 2,
  parameter int DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic       [FETCH_W-1:0]     in_valid,
  input  virt_t      [FETCH_W-1:0]     in_pc,
  input  uint32_t    [FETCH_W-1:0]     in_inst,
  input  operation_t [FETCH_W-1:0]     in_operation,
  input  exception_t [FETCH_W-1:0]     in_exception,
  output logic                         in_ready,
  output logic       [OUT_W-1:0]       out_valid,
  output uop_t       [OUT_W-1:0]       out_uop,
  input  logic                         out_ready,
  output logic       [$clog2(DEPTH):0] occupancy
);

  localparam int PW  = ptr_width(DEPTH);
  localparam int AW  = PW - 1;
  localparam int GRP = DEPTH_MIN * FETCH_W;

  uop_t [2*FETCH_W-1:0] exp_uops;
  logic [PW-1:0]        exp_cnt;

  uop_expander #(
    .FETCH_W (FETCH_W),
    .CNT_W   (PW)
  ) u_expander (
    .valid_i     (in_valid),
    .pc_i        (in_pc),
    .inst_i      (in_inst),
    .operation_i (in_operation),
    .exception_i (in_exception),
    .uops_o      (exp_uops),
    .count_o     (exp_cnt)
  );

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]    occ, enq_cnt, deq_cnt;
  logic             accept;
  uop_t             mem_q [DEPTH];
  uop_t [OUT_W-1:0] rd_uop;
  logic [OUT_W-1:0] raw_valid, vis_valid;

  // Worst-case group space check on registered state only: no path from in_valid.
  assign occ       = tail_q - head_q;
  assign occupancy = occ;
  assign in_ready  = (PW'(DEPTH) - occ) >= PW'(GRP);
  assign accept    = in_ready && (|in_valid) && !flush && !reset;
  assign enq_cnt   = accept ? exp_cnt : '0;

  always_comb begin
    for (int i = 0; i < OUT_W; i++) begin
      raw_valid[i] = occ > PW'(i);
      rd_uop[i]    = mem_q[AW'(head_q + PW'(i))];
    end
  end

  always_comb begin
    vis_valid = raw_valid;
`ifdef DECODE_ATOMIC_PAIR_EN
    if (OUT_W > 1) begin : g_pair_trim
      logic keep;
      keep = 1'b1;
      for (int i = 0; i < OUT_W; i++) begin
        if (!rd_uop[i].is_inst2 && is_cracked_op(rd_uop[i].operation) &&
            !rd_uop[i].exception.ex &&
            ((i == OUT_W - 1) || !raw_valid[(i + 1) % OUT_W])) begin
          keep = 1'b0;
        end
        vis_valid[i] = raw_valid[i] && keep;
      end
    end
`endif
  end

  always_comb begin
    deq_cnt = '0;
    for (int i = 0; i < OUT_W; i++) begin
      out_uop[i] = vis_valid[i] ? rd_uop[i] : '0;
      deq_cnt    = deq_cnt + PW'(vis_valid[i]);
    end
    if (!out_ready) begin
      deq_cnt = '0;
    end
  end

  assign out_valid = vis_valid;
  assign head_d    = head_q + deq_cnt;
  assign tail_d    = tail_q + enq_cnt;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2 * FETCH_W; k++) begin
      if (PW'(k) < enq_cnt) begin
        mem_q[AW'(tail_q + PW'(k))] <= exp_uops[k];
      end
    end
  end

`ifndef SYNTHESIS
  logic [FETCH_W:0] valid_inc;
  assign valid_inc = {1'b0, in_valid} + {{FETCH_W{1'b0}}, 1'b1};

  a_valid_thermometer : assert property (@(posedge clk) disable iff (reset)
    (({1'b0, in_valid} & valid_inc) == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_uop_queue.sv
`default_nettype none
//============================================================================
// Module   : tb_decode_uop_queue
// Brief    : Directed plus random bench with a queue-based reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_decode_uop_queue;
  import decode_uop_queue_pkg::*;

  localparam int FETCH_W = 2;
  localparam int OUT_W   = 2;
  localparam int DEPTH   = 16;

  logic                         clk = 1'b0;
  logic                         reset, flush, in_ready, out_ready;
  logic       [FETCH_W-1:0]     in_valid;
  virt_t      [FETCH_W-1:0]     in_pc;
  uint32_t    [FETCH_W-1:0]     in_inst;
  operation_t [FETCH_W-1:0]     in_operation;
  exception_t [FETCH_W-1:0]     in_exception;
  logic       [OUT_W-1:0]       out_valid;
  uop_t       [OUT_W-1:0]       out_uop;
  logic       [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  decode_uop_queue #(
    .FETCH_W (FETCH_W),
    .OUT_W   (OUT_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_operation (in_operation),
    .in_exception (in_exception),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_uop      (out_uop),
    .out_ready    (out_ready),
    .occupancy    (occupancy)
  );

  uop_t mq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_cracked(input operation_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
                      OP_MSUB, OP_MSUBU, OP_MUL};
  endfunction

  function automatic int ref_visible();
    int n;
    n = (mq.size() < OUT_W) ? mq.size() : OUT_W;
`ifdef DECODE_ATOMIC_PAIR_EN
    if (OUT_W > 1) begin
      for (int i = 0; i < n; i++) begin
        if (!mq[i].is_inst2 && ref_cracked(mq[i].operation) && !mq[i].exception.ex &&
            ((i == OUT_W - 1) || (i + 1 >= mq.size()))) return i;
      end
    end
`endif
    return n;
  endfunction

  task automatic ref_step();
    int vis;
    bit rdy;
    if (reset || flush) begin
      mq.delete();
      return;
    end
    vis = ref_visible();
    rdy = (DEPTH - mq.size()) >= 2 * FETCH_W;
    if (out_ready) repeat (vis) void'(mq.pop_front());
    if (rdy) begin
      for (int l = 0; l < FETCH_W; l++) begin
        if (in_valid[l]) begin
          uop_t u;
          u.pc        = in_pc[l];
          u.inst      = in_inst[l];
          u.operation = in_operation[l];
          u.exception = in_exception[l];
          u.is_inst2  = 1'b0;
          mq.push_back(u);
          if (ref_cracked(in_operation[l]) && !in_exception[l].ex) begin
            u.is_inst2 = 1'b1;
            mq.push_back(u);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    int   vis;
    uop_t e;
    vis = ref_visible();
    check_eq("occupancy", occupancy, mq.size());
    check_eq("in_ready", in_ready, (DEPTH - mq.size()) >= 2 * FETCH_W);
    for (int i = 0; i < OUT_W; i++) begin
      e = (i < vis) ? mq[i] : '0;
      check_eq($sformatf("out_valid%0d", i), out_valid[i], i < vis);
      check_eq($sformatf("out_uop%0d", i), out_uop[i], e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ref_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_lane(input int l, input operation_t op, input logic [31:0] pc,
                          input bit ex, input logic [4:0] code);
    in_pc[l]                  = pc;
    in_inst[l]                = $urandom;
    in_operation[l]           = op;
    in_exception[l].ex        = ex;
    in_exception[l].exccode   = code;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = '0;
    in_pc = '0; in_inst = '0; in_operation = {FETCH_W{OP_NOP}}; in_exception = '0;
    @(negedge clk);
    tick();
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, '0);
    check_eq("rst_out_uop", out_uop, '0);
    reset = 1'b0;

    // Two plain ops, one uop each.
    set_lane(0, OP_ADDU, 32'h8000_0000, 1'b0, EXC_INT);
    set_lane(1, OP_ADDU, 32'h8000_0004, 1'b0, EXC_INT);
    in_valid = 2'b11; out_ready = 1'b1;
    tick();
    in_valid = '0;
    check_eq("t1_valid", out_valid, 2'b11);
    check_eq("t1_pc0", out_uop[0].pc, 32'h8000_0000);
    check_eq("t1_pc1", out_uop[1].pc, 32'h8000_0004);
    check_eq("t1_inst2", {out_uop[1].is_inst2, out_uop[0].is_inst2}, 2'b00);
    check_eq("t1_occ", occupancy, 2);
    tick();

    // Cracked MADD ahead of OR.
    out_ready = 1'b0;
    set_lane(0, OP_MADD, 32'h100, 1'b0, EXC_INT);
    set_lane(1, OP_OR, 32'h104, 1'b0, EXC_INT);
    in_valid = 2'b11;
    tick();
    in_valid = '0;
    check_eq("t2_occ", occupancy, 3);
    check_eq("t2_u0", {out_uop[0].operation, out_uop[0].is_inst2}, {OP_MADD, 1'b0});
    check_eq("t2_u1", {out_uop[1].operation, out_uop[1].is_inst2}, {OP_MADD, 1'b1});
    out_ready = 1'b1;
    tick();
    check_eq("t2_or", out_uop[0].operation, OP_OR);
    check_eq("t2_or_valid", out_valid, 2'b01);
    tick();

    // Fill with MULT pairs until back-pressure.
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) begin
      set_lane(0, OP_MULT, 32'h300 + 8 * g, 1'b0, EXC_INT);
      set_lane(1, OP_MULT, 32'h304 + 8 * g, 1'b0, EXC_INT);
      in_valid = 2'b11;
      tick();
      check_eq("t3_occ", occupancy, (g < 4) ? 4 * (g + 1) : 16);
      check_eq("t3_rdy", in_ready, g < 3);
    end
    in_valid = '0; out_ready = 1'b1;
    repeat (8) tick();

    // Move pointers to index 15, then straddle the wrap point.
    set_lane(0, OP_ADDU, 32'h400, 1'b0, EXC_INT);
    set_lane(1, OP_ADDU, 32'h404, 1'b0, EXC_INT);
    in_valid = 2'b11;
    repeat (5) tick();
    in_valid = '0;
    repeat (2) tick();
    out_ready = 1'b0;
    set_lane(0, OP_MULT, 32'h200, 1'b0, EXC_INT);
    set_lane(1, OP_MULTU, 32'h204, 1'b0, EXC_INT);
    in_valid = 2'b11;
    tick();
    in_valid = '0;
    check_eq("t4_occ", occupancy, 4);
    check_eq("t4_u0", {out_uop[0].pc, out_uop[0].is_inst2}, {32'h200, 1'b0});
    out_ready = 1'b1;
    tick();
    check_eq("t4_u2", {out_uop[0].pc, out_uop[0].operation, out_uop[0].is_inst2},
             {32'h204, OP_MULTU, 1'b0});
    check_eq("t4_u3", {out_uop[1].pc, out_uop[1].is_inst2}, {32'h204, 1'b1});
    tick();

    // Faulting MUL is not cracked.
    out_ready = 1'b0;
    set_lane(0, OP_MUL, 32'h500, 1'b1, EXC_ADEL);
    in_valid = 2'b01;
    tick();
    check_eq("t5_occ", occupancy, 1);
    check_eq("t5_valid", out_valid, 2'b01);
    check_eq("t5_inst2", out_uop[0].is_inst2, 1'b0);
    check_eq("t5_exc", out_uop[0].exception, {1'b1, EXC_ADEL});
    set_lane(0, OP_ADDU, 32'h504, 1'b0, EXC_INT);
    set_lane(1, OP_ADDU, 32'h508, 1'b0, EXC_INT);
    in_valid = 2'b11;
    tick();

    // Flush beats a simultaneous enqueue and dequeue.
    flush = 1'b1; out_ready = 1'b1;
    set_lane(0, OP_MULT, 32'h600, 1'b0, EXC_INT);
    set_lane(1, OP_DIV, 32'h604, 1'b0, EXC_INT);
    in_valid = 2'b11;
    tick();
    flush = 1'b0; in_valid = '0;
    check_eq("t6_occ", occupancy, 0);
    check_eq("t6_valid", out_valid, '0);
    tick();
    check_eq("t6_occ2", occupancy, 0);

    for (int it = 0; it < 3000; it++) begin
      int n;
      reset = (it == 1500);
      flush = ($urandom_range(0, 63) == 0);
      n = $urandom_range(0, FETCH_W);
      in_valid = FETCH_W'((1 << n) - 1);
      for (int l = 0; l < FETCH_W; l++) begin
        set_lane(l, operation_t'($urandom_range(0, 16)), $urandom,
                 ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)));
      end
      if (((it / 200) % 3) == 0) out_ready = ($urandom_range(0, 3) == 0);
      else                       out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
